div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 26 ++
 rtl/div_scheduler.sv | 118 +++++++++++
 tb/tb_div_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state type for the divide scheduler.
// Widths, step count and FSM encoding used by div_scheduler/div_step.
package div_pkg;

  localparam int A_W   = 64;
  localparam int B_W   = 32;
  localparam int STEPS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem,quot}.
// In: rem, quot, b. Out: rem_nx (B_W+1, MSB always 0), quot_nx.
module div_step #(
  parameter int A_W = 64,
  parameter int B_W = 32
) (
  input  logic [B_W-1:0] rem,
  input  logic [A_W-1:0] quot,
  input  logic [B_W-1:0] b,
  output logic [B_W:0]   rem_nx,
  output logic [A_W-1:0] quot_nx
);

  logic [B_W:0] sh;
  logic [B_W:0] diff;
  logic         ge;

  // rem < b on entry, so the shifted value is < 2b and
  // the difference always fits back into B_W bits.
  assign sh      = {rem, quot[A_W-1]};
  assign ge      = sh >= {1'b0, b};
  assign diff    = sh - {1'b0, b};
  assign rem_nx  = ge ? diff : sh;
  assign quot_nx = {quot[A_W-2:0], ge};

endmodule

// File: rtl/div_scheduler.sv
// Two-requester round-robin front end to a 64-step divider.
// Ports: clk/rst, req_valid/ready/a/b in, rsp_valid/ready/id/quot/rem/dz out.
module div_scheduler #(
  parameter int A_W   = 64,
  parameter int B_W   = 32,
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [A_W-1:0]     rsp_quot,
  output logic [A_W-1:0]     rsp_rem,
  output logic               rsp_dz
);

  import div_pkg::*;

  div_state_t     state;
  logic           ptr;
  logic [5:0]     cnt;
  logic [B_W-1:0] b_q;
  logic [A_W-1:0] quot;
  logic [A_W-1:0] rem;

  logic           gid;
  logic [A_W-1:0] a_sel;
  logic [B_W-1:0] b_sel;
  logic [B_W:0]   rem_nx;
  logic [A_W-1:0] quot_nx;
  logic           acc;

  // Favour the pointer's requester, else fall back to the other.
  always_comb begin
    gid = ptr;
    if (!req_valid[ptr]) gid = ~ptr;
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && req_valid[gid])
      req_ready[gid] = 1'b1;
  end

  assign acc   = |req_ready;
  assign a_sel = req_a[gid*A_W +: A_W];
  assign b_sel = req_b[gid*B_W +: B_W];

  div_step #(.A_W(A_W), .B_W(B_W)) u_step (
    .rem     (rem[B_W-1:0]),
    .quot    (quot),
    .b       (b_q),
    .rem_nx  (rem_nx),
    .quot_nx (quot_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      b_q       <= '0;
      quot      <= '0;
      rem       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_dz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            ptr    <= ~gid;
            rsp_id <= gid;
            b_q    <= b_sel;
            if (b_sel == '0) begin
              quot      <= '1;
              rem       <= a_sel;
              rsp_dz    <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              quot   <= a_sel;
              rem    <= '0;
              cnt    <= '0;
              rsp_dz <= 1'b0;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          quot <= quot_nx;
          rem  <= A_W'(rem_nx);
          cnt  <= cnt + 6'd1;
          if (cnt == 6'(STEPS - 1)) begin
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_quot = quot;
  assign rsp_rem  = rem;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: vector table plus
// arbitration, stall and mid-operation reset sequences.
module tb_div_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_a;
  logic [63:0]  req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [63:0]  rsp_quot;
  logic [63:0]  rsp_rem;
  logic         rsp_dz;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_quot  (rsp_quot),
    .rsp_rem   (rsp_rem),
    .rsp_dz    (rsp_dz)
  );

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_dz", 64'(rsp_dz), 64'd0);
    chk("rst_quot", rsp_quot, 64'd0);
    chk("rst_rem", rsp_rem, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

  // Issue one request and return the edge count from the accept
  // edge (inclusive) to the first edge after which rsp_valid is high.
  task automatic txn(input int id, input logic [63:0] a,
                     input logic [31:0] b, output int lat);
    int w;
    @(negedge clk);
    req_a = '0;
    req_b = '0;
    req_a[id*64 +: 64] = a;
    req_b[id*32 +: 32] = b;
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[id] && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("accept_timeout", 64'(w < 200), 64'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      if (lat == 0) req_valid = '0;
      lat++;
    end while (!rsp_valid && lat < 200);
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int w;
    int seen;
    logic [63:0] all1;
    all1 = '1;

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{0, 64'd100, 32'd7, 64'd14, 64'd2, 1'b0, 65};
    vecs[1] = '{1, 64'd55, 32'd0, all1, 64'd55, 1'b1, 1};
    vecs[2] = '{0, all1, 32'hFFFF_FFFF,
                64'h0000_0001_0000_0001, 64'd0, 1'b0, 65};
    vecs[3] = '{1, 64'd1000000, 32'd1000, 64'd1000, 64'd0, 1'b0, 65};
    vecs[4] = '{0, 64'd5, 32'd9, 64'd0, 64'd5, 1'b0, 65};
    vecs[5] = '{1, 64'h0123_4567_89AB_CDEF, 32'h0001_0000,
                64'h0000_0123_4567_89AB, 64'h0000_0000_0000_CDEF,
                1'b0, 65};
    vecs[6] = '{0, 64'd0, 32'd0, all1, 64'd0, 1'b1, 1};
    vecs[7] = '{1, 64'h8000_0000_0000_0000, 32'd3,
                64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 65};

    do_reset();

    foreach (vecs[i]) begin
      txn(vecs[i].id, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_quot", i), rsp_quot, vecs[i].q);
      chk($sformatf("v%0d_rem", i), rsp_rem, vecs[i].r);
      chk($sformatf("v%0d_id", i), 64'(rsp_id), 64'(vecs[i].id));
      chk($sformatf("v%0d_dz", i), 64'(rsp_dz), 64'(vecs[i].dz));
      release_rsp();
    end

    // Round robin with both requesters continuously valid.
    do_reset();
    @(negedge clk);
    req_a = {64'd55, 64'd100};
    req_b = {32'd5, 32'd7};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (req_ready == 2'b00 && w < 200) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk($sformatf("rr%0d_gnt", k), 64'(req_ready),
          (k % 2) ? 64'd2 : 64'd1);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!rsp_valid && lat < 200);
      chk($sformatf("rr%0d_id", k), 64'(rsp_id), 64'(k % 2));
      chk($sformatf("rr%0d_quot", k), rsp_quot,
          (k % 2) ? 64'd11 : 64'd14);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_noacc_done", k), 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    if (rsp_valid) release_rsp();

    // Long stall with inputs wiggling underneath.
    do_reset();
    txn(0, all1, 32'd1, lat);
    chk("stall_lat", 64'(lat), 64'd65);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 2'(c);
      req_a = {2{64'(c * 77)}};
      req_b = {2{32'(c)}};
      #1;
      chk($sformatf("stall%0d_v", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d_q", c), rsp_quot, all1);
      chk($sformatf("stall%0d_r", c), rsp_rem, 64'd0);
      chk($sformatf("stall%0d_meta", c),
          {62'd0, rsp_id, rsp_dz}, 64'd0);
      chk($sformatf("stall%0d_rdy", c), 64'(req_ready), 64'd0);
    end
    req_valid = 2'b00;
    release_rsp();
    @(negedge clk);
    #1;
    chk("stall_drop", 64'(rsp_valid), 64'd0);

    // Reset in the middle of BUSY aborts the operation.
    txn(0, 64'd100, 32'd7, lat);
    release_rsp();
    @(negedge clk);
    req_a = 128'd100;
    req_b = 64'd7;
    req_valid = 2'b01;
    #1;
    w = 0;
    while (!req_ready[0] && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(posedge clk);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("abort_rdy_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    chk("abort_quot", rsp_quot, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    txn(1, 64'd1000, 32'd10, lat);
    chk("fresh_lat", 64'(lat), 64'd65);
    chk("fresh_quot", rsp_quot, 64'd100);
    chk("fresh_rem", rsp_rem, 64'd0);
    chk("fresh_id", 64'(rsp_id), 64'd1);
    release_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
